branch_resolver: RTL and testbench

Back-end partner of the decode-stage branch predictor: it accepts each branch's predicted direction at decode and holds in-flight predictions in order. At execute it receives the actual outcome, compares it with the prediction, and on a mismatch issues a registered flush plus a redirect PC to fetch. It owns the 2-bit saturating branch history table (BHT) that supplies predictions, and it maintains optional branch/mispredict statistics.

---
 rtl/branch_pkg.sv | 16 +
 rtl/branch_fifo.sv | 37 +++
 rtl/branch_resolver.sv | 86 ++++++++
 tb/tb_branch_resolver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch predictor / resolver pair.
package branch_pkg;
   typedef enum logic [1:0] {SNT, WNT, WT, ST} bht_state_t;
   localparam int BR_PC_W = 32;
   typedef struct packed {
      logic [BR_PC_W-1:0] pc;
      logic [BR_PC_W-1:0] target;
      logic               taken;
   } br_entry_t;
   localparam int PC_INC = 4;
   localparam bht_state_t BHT_RESET = WNT;
   function automatic bht_state_t bht_next(bht_state_t s, logic taken);
      return taken ? ((s == ST) ? ST : bht_state_t'(s + 2'd1))
                   : ((s == SNT) ? SNT : bht_state_t'(s - 2'd1));
   endfunction
endpackage

// File: rtl/branch_fifo.sv
// branch_fifo: synchronous FIFO of in-flight branches; clear wins over push.
module branch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
   end
   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = wr_ptr == rd_ptr;
   assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: in-order branch resolution, mispredict flush/redirect and 2-bit BHT.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int BHT_ENTRIES = 16,
   parameter int PC_W        = 32,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_valid,
   input  logic [PC_W-1:0]  pred_pc,
   input  logic [PC_W-1:0]  pred_target,
   input  logic             pred_taken,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  bht_pc,
   output logic             bht_predict,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             res_error,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);
   localparam int IW = $clog2(BHT_ENTRIES);
   localparam int EW = 2*PC_W + 1;
   logic [EW-1:0]   head;
   logic [PC_W-1:0] head_pc, head_target;
   logic            head_taken, full, empty, push, resolve, mismatch;
   logic [IW-1:0]   head_idx, look_idx;
   bht_state_t      bht [BHT_ENTRIES];
   logic            unused_bits;
   assign head_pc     = head[EW-1 -: PC_W];
   assign head_target = head[PC_W:1];
   assign head_taken  = head[0];
   assign pred_ready  = !full && !flush;
   assign push        = pred_valid && pred_ready;
   assign resolve     = res_valid && !empty;
   assign mismatch    = resolve && (head_taken != res_taken);
   assign head_idx    = head_pc[IW+1:2];
   assign look_idx    = bht_pc[IW+1:2];
   assign bht_predict = bht[look_idx] >= WT;
   assign unused_bits = &{1'b0, bht_pc[PC_W-1:IW+2], bht_pc[1:0]};
   // a mispredict clears the queue, dropping any same-cycle wrong-path push
   branch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (resolve),
      .clear (mismatch),
      .wdata ({pred_pc, pred_target, pred_taken}),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush       <= 1'b0;
         redirect_pc <= '0;
         res_error   <= 1'b0;
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET;
      end else begin
         flush     <= mismatch;
         res_error <= res_valid && empty;
         if (mismatch) redirect_pc <= res_taken ? head_target : head_pc + PC_W'(PC_INC);
         if (resolve) bht[head_idx] <= bht_next(bht[head_idx], res_taken);
      end
   end
`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (resolve) begin
         branch_count <= branch_count + CNT_W'(branch_count != '1);
         if (mismatch) mispredict_count <= mispredict_count + CNT_W'(mispredict_count != '1);
      end
   end
`else
   assign branch_count     = '0;
   assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors against a queue-based reference model of branch_resolver.
module tb_branch_resolver;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
   logic [31:0] pred_pc = '0, pred_target = '0, bht_pc = 32'h100;
   logic        pred_ready, bht_predict, flush, res_error;
   logic [31:0] redirect_pc;
   logic [15:0] branch_count, mispredict_count;
   int          errors = 0, checks = 0;

   branch_resolver dut (
      .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
      .pred_target(pred_target), .pred_taken(pred_taken), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .bht_pc(bht_pc),
      .bht_predict(bht_predict), .flush(flush), .redirect_pc(redirect_pc),
      .res_error(res_error), .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] pc; logic [31:0] tgt; logic tk;} ent_t;
   ent_t        q[$];
   ent_t        h;
   int          bht_m [16];
   int          e_bc, e_mc;
   logic        e_flush, e_err, m_push, m_mis;
   logic [31:0] e_red;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < 16; i++) bht_m[i] = 1;
         e_bc = 0; e_mc = 0; e_flush = 0; e_err = 0; e_red = 0;
      end else begin
         m_push = pred_valid && (q.size() < 4) && !e_flush;
         m_mis  = 0;
         e_err  = res_valid && (q.size() == 0);
         if (res_valid && q.size() > 0) begin
            h = q.pop_front();
            m_mis = h.tk != res_taken;
            bht_m[h.pc[5:2]] = res_taken ? ((bht_m[h.pc[5:2]] < 3) ? bht_m[h.pc[5:2]] + 1 : 3)
                                         : ((bht_m[h.pc[5:2]] > 0) ? bht_m[h.pc[5:2]] - 1 : 0);
            if (e_bc < 65535) e_bc++;
            if (m_mis) begin
               if (e_mc < 65535) e_mc++;
               q.delete();
               e_red = res_taken ? h.tgt : h.pc + 32'd4;
            end
         end
         e_flush = m_mis;
         if (m_push && !m_mis) q.push_back('{pred_pc, pred_target, pred_taken});
      end
   end

   always @(negedge clk) begin
      chk("pred_ready", pred_ready, (q.size() < 4) && !e_flush);
      chk("bht_predict", bht_predict, bht_m[bht_pc[5:2]] >= 2);
      chk("flush", flush, e_flush);
      if (e_flush) chk("redirect_pc", redirect_pc, e_red);
      chk("res_error", res_error, e_err);
      chk("branch_count", branch_count, STATS ? e_bc : 0);
      chk("mispredict_count", mispredict_count, STATS ? e_mc : 0);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      pred_valid = 1; pred_pc = pc; pred_target = tgt; pred_taken = tk;
      cyc();
      pred_valid = 0;
   endtask

   task automatic resolve(input logic tk);
      res_valid = 1; res_taken = tk;
      cyc();
      res_valid = 0;
   endtask

   initial begin
      #12 rst_n = 1;
      cyc();
      chk("lit reset bht_predict", bht_predict, 0);
      chk("lit reset pred_ready", pred_ready, 1);
      chk("lit reset flush", flush, 0);
      chk("lit reset redirect", redirect_pc, 0);
      chk("lit reset counts", {branch_count, mispredict_count}, 0);
      push(32'h100, 32'h140, 0);
      resolve(1);
      chk("lit flush taken", flush, 1);
      chk("lit redirect taken", redirect_pc, 32'h140);
      chk("lit mispredict 1", mispredict_count, STATS ? 1 : 0);
      chk("lit bht 0x100 WT", bht_predict, 1);
      cyc();
      chk("lit flush one cycle", flush, 0);
      push(32'h200, 32'h180, 1);
      resolve(0);
      chk("lit redirect not-taken", redirect_pc, 32'h204);
      cyc();
      for (int i = 0; i < 4; i++) push(32'h300 + 32'(4*i), 32'h380, 1);
      chk("lit full not ready", pred_ready, 0);
      resolve(1);
      pred_valid = 1; pred_pc = 32'h310; pred_target = 32'h380; pred_taken = 1;
      resolve(1);
      pred_valid = 0;
      chk("lit push+pop ready", pred_ready, 1);
      push(32'h314, 32'h380, 1);
      chk("lit refilled full", pred_ready, 0);
      resolve(1);
      pred_valid = 1; pred_pc = 32'h318; pred_target = 32'h380; pred_taken = 1;
      resolve(0);
      pred_valid = 0;
      chk("lit redirect 30C", redirect_pc, 32'h310);
      res_valid = 1; res_taken = 1;
      cyc();
      res_valid = 0;
      chk("lit res_error pulse", res_error, 1);
      cyc();
      chk("lit res_error cleared", res_error, 0);
      bht_pc = 32'h43C;
      for (int i = 0; i < 5; i++) begin
         push(32'h43C, 32'h500, 1);
         resolve(1);
      end
      chk("lit ST predict", bht_predict, 1);
      push(32'h43C, 32'h500, 1);
      resolve(0);
      chk("lit ST->WT predict", bht_predict, 1);
      cyc();
      push(32'h43C, 32'h500, 0);
      resolve(0);
      chk("lit WT->WNT predict", bht_predict, 0);
      bht_pc = 32'h100;
      for (int i = 0; i < 3; i++) push(32'h600 + 32'(4*i), 32'h700, 0);
      res_valid = 1; res_taken = 1;
      #3 rst_n = 0;
      #1;
      chk("lit async pred_ready", pred_ready, 1);
      chk("lit async flush", flush, 0);
      chk("lit async redirect", redirect_pc, 0);
      chk("lit async counts", {branch_count, mispredict_count}, 0);
      chk("lit async bht", bht_predict, 0);
      res_valid = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      resolve(1);
      chk("lit empty after reset", res_error, 1);
      for (int i = 0; i < 10; i++) begin
         push(32'h800 + 32'(4*i), 32'h900, 0);
         resolve(1);
         cyc();
      end
      chk("lit 10 mispredicts", mispredict_count, STATS ? 10 : 0);
      chk("lit 10 branches", branch_count, STATS ? 11 - 1 : 0);
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
